// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard scheduler: writeback source, forward mux selects, FSM states.
// Latency: n/a (types and pure functions only). Backpressure: n/a.
// Holds the register-match helper used by both the forwarding unit and the load-use detector.
package hazard_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10
    } wb_sel_e;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        LDSTALL = 1'b1
    } hz_state_e;

    // x0 is hardwired zero, so it can never be a producer worth tracking.
    function automatic logic reg_match(input logic [4:0] x, input logic [4:0] y);
        return (x == y) && (x != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_e_sel(input logic       wren_m,
                                             input logic [4:0] rd_m,
                                             input logic       wren_w,
                                             input logic [4:0] rd_w,
                                             input logic [4:0] rs);
        if (wren_m && reg_match(rd_m, rs)) begin
            return FWD_MEM;
        end else if (wren_w && reg_match(rd_w, rs)) begin
            return FWD_WB;
        end
        return FWD_NONE;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational operand forwarding selects for the decode and execute stages.
// Latency: zero cycles, pure combinational compares. Backpressure: none, no state.
// M beats W for execute operands since M holds the younger result.
module fwd_unit
    import hazard_pkg::*;
(
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       rd_wren_m,
    input  logic       rd_wren_w,
    input  logic [1:0] wb_sel_m,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e
);

    logic m_is_alu;

    // A load in M has no data yet; only ALU/PC results can be bypassed into decode.
    assign m_is_alu = (wb_sel_m != WB_MEM);

    assign fwd_a_d = rd_wren_m && m_is_alu && reg_match(rd_m, rs1_d);
    assign fwd_b_d = rd_wren_m && m_is_alu && reg_match(rd_m, rs2_d);

    assign fwd_a_e = fwd_e_sel(rd_wren_m, rd_m, rd_wren_w, rd_w, rs1_e);
    assign fwd_b_e = fwd_e_sel(rd_wren_m, rd_m, rd_wren_w, rd_w, rs2_e);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard scheduler: load-use stall FSM, mispredict flush, operand forward selects.
// Latency: outputs combinational from state+inputs, take effect at next edge; load-use holds D LOAD_STALL cycles.
// Backpressure: stall_f/stall_d hold upstream regs; HAZARD_PERF_CNT_EN adds saturating stall/flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_insn_vld_d,
    input  logic [4:0]       i_rs1_d,
    input  logic [4:0]       i_rs2_d,
    input  logic [4:0]       i_rs1_e,
    input  logic [4:0]       i_rs2_e,
    input  logic [4:0]       i_rd_e,
    input  logic [4:0]       i_rd_m,
    input  logic [4:0]       i_rd_w,
    input  logic             i_rd_wren_e,
    input  logic             i_rd_wren_m,
    input  logic             i_rd_wren_w,
    input  logic [1:0]       i_wb_sel_e,
    input  logic [1:0]       i_wb_sel_m,
    input  logic             i_mispredict_e,
    output logic             o_stall_f,
    output logic             o_stall_d,
    output logic             o_flush_d,
    output logic             o_flush_e,
    output logic             o_forward_a_d,
    output logic             o_forward_b_d,
    output logic [1:0]       o_forward_a_e,
    output logic [1:0]       o_forward_b_e,
`ifdef HAZARD_PERF_CNT_EN
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt,
`endif
    output logic             o_busy
);

    localparam int CNT_BITS = (LOAD_STALL > 2) ? $clog2(LOAD_STALL - 1) : 1;
    localparam logic [CNT_BITS-1:0] CNT_INIT =
        (LOAD_STALL > 1) ? CNT_BITS'(LOAD_STALL - 2) : '0;

    if (LOAD_STALL < 1 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl: LOAD_STALL and CNT_W must be >= 1");
    end

    hz_state_e           state, state_nxt;
    logic [CNT_BITS-1:0] cnt, cnt_nxt;
    logic                lu;
    logic                stall, flush_d, flush_e;
    logic                fwd_a_d, fwd_b_d;
    logic [1:0]          fwd_a_e, fwd_b_e;

    fwd_unit u_fwd (
        .rs1_d     (i_rs1_d),
        .rs2_d     (i_rs2_d),
        .rs1_e     (i_rs1_e),
        .rs2_e     (i_rs2_e),
        .rd_m      (i_rd_m),
        .rd_w      (i_rd_w),
        .rd_wren_m (i_rd_wren_m),
        .rd_wren_w (i_rd_wren_w),
        .wb_sel_m  (i_wb_sel_m),
        .fwd_a_d   (fwd_a_d),
        .fwd_b_d   (fwd_b_d),
        .fwd_a_e   (fwd_a_e),
        .fwd_b_e   (fwd_b_e)
    );

    assign lu = i_insn_vld_d && i_rd_wren_e && (i_wb_sel_e == WB_MEM) &&
                (reg_match(i_rd_e, i_rs1_d) || reg_match(i_rd_e, i_rs2_d));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // The first stall cycle is spent in RUN, so LDSTALL only covers the remaining LOAD_STALL-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;
        unique case (state)
            RUN: begin
                if (i_mispredict_e) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (lu) begin
                    stall   = 1'b1;
                    flush_e = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_nxt = LDSTALL;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            LDSTALL: begin
                if (i_mispredict_e) begin
                    flush_d   = 1'b1;
                    flush_e   = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    stall   = 1'b1;
                    flush_e = 1'b1;
                    if (cnt == '0) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Every output is forced quiet while reset is held, including the combinational forwards.
    assign o_stall_f     = i_rst_n && stall;
    assign o_stall_d     = i_rst_n && stall;
    assign o_flush_d     = i_rst_n && flush_d;
    assign o_flush_e     = i_rst_n && flush_e;
    assign o_busy        = i_rst_n && (state != RUN);
    assign o_forward_a_d = i_rst_n && fwd_a_d;
    assign o_forward_b_d = i_rst_n && fwd_b_d;
    assign o_forward_a_e = i_rst_n ? fwd_a_e : FWD_NONE;
    assign o_forward_b_e = i_rst_n ? fwd_b_e : FWD_NONE;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (stall && !(&o_stall_cnt)) begin
                o_stall_cnt <= o_stall_cnt + 1'b1;
            end
            if (i_mispredict_e && !(&o_flush_cnt)) begin
                o_flush_cnt <= o_flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
